apb2axi_axi_responder: RTL

AXI3 slave-side response engine for the APB2AXI bridge. It accepts AR, AW and W traffic, generates R data beats and B write responses, and drives the same R/B channels that the bridge's response collector consumes. It is the synthesizable counterpart used in the block-level bench and the FPGA loopback build. Read data is a deterministic function of beat address, so every returned beat is self-checking.

---
 rtl/apb2axi_axi_responder_if.sv | 45 ++++
 rtl/apb2axi_axi_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/apb2axi_axi_responder_if.sv
// rtl/apb2axi_axi_responder_if.sv - AXI3 AR/R/AW/W/B bundle between bridge master and responder slave
interface apb2axi_axi_responder_if #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32
);
   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [3:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arvalid;
   logic              arready;
   logic [ID_W-1:0]   rid;
   logic [63:0]       rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;
   logic [ID_W-1:0]   awid;
   logic [ADDR_W-1:0] awaddr;
   logic [3:0]        awlen;
   logic              awvalid;
   logic              awready;
   logic [ID_W-1:0]   wid;
   logic [63:0]       wdata;
   logic [7:0]        wstrb;
   logic              wlast;
   logic              wvalid;
   logic              wready;
   logic [ID_W-1:0]   bid;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output awid, awaddr, awlen, awvalid, wid, wdata, wstrb, wlast, wvalid, bready,
      input  arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
   );
   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  awid, awaddr, awlen, awvalid, wid, wdata, wstrb, wlast, wvalid, bready,
      output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
   );
endinterface

// File: rtl/apb2axi_axi_responder.sv
// rtl/apb2axi_axi_responder.sv - AXI3 slave response engine; address-window SLVERR under APB2AXI_RSP_ERR_INJ_EN
module apb2axi_axi_responder #(
   parameter int                ID_W     = 4,
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 64,
   parameter int                AR_DEPTH = 4,
   parameter int                AW_DEPTH = 4,
   parameter int                B_DEPTH  = 4,
   parameter logic [ADDR_W-1:0] ERR_BASE = 32'hF000_0000,
   parameter logic [ADDR_W-1:0] ERR_SIZE = 32'h0000_1000
) (
   input logic                    aclk,
   input logic                    aresetn,
   apb2axi_axi_responder_if.slave axi
);
   localparam int ARW = $clog2(AR_DEPTH);
   localparam int AWW = $clog2(AW_DEPTH);
   localparam int BW  = $clog2(B_DEPTH);
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
`ifdef APB2AXI_RSP_ERR_INJ_EN
   localparam bit ERR_INJ = 1'b1;
`else
   localparam bit ERR_INJ = 1'b0;
`endif

   typedef enum logic {R_IDLE, R_BURST} r_state_t;

   function automatic logic err_win(input logic [ADDR_W-1:0] a);
      return ERR_INJ && (a >= ERR_BASE) && ((a - ERR_BASE) < ERR_SIZE);
   endfunction

   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
      return {~a[31:0], a[31:0]};
   endfunction

   // ---------------- AR queue ----------------
   logic [ID_W-1:0]   arq_id    [AR_DEPTH];
   logic [ADDR_W-1:0] arq_addr  [AR_DEPTH];
   logic [3:0]        arq_len   [AR_DEPTH];
   logic [2:0]        arq_size  [AR_DEPTH];
   logic [1:0]        arq_burst [AR_DEPTH];
   logic [ARW-1:0]    ar_wp, ar_rp;
   logic [ARW:0]      ar_cnt, ar_cnt_nxt;
   logic              ar_rdy, ar_push, ar_pop;

   assign ar_push    = axi.arvalid && ar_rdy;
   assign ar_cnt_nxt = ar_cnt + (ARW+1)'(ar_push) - (ARW+1)'(ar_pop);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         ar_wp  <= '0;
         ar_rp  <= '0;
         ar_cnt <= '0;
         ar_rdy <= 1'b0;
      end else begin
         if (ar_push) begin
            arq_id[ar_wp]    <= axi.arid;
            arq_addr[ar_wp]  <= axi.araddr;
            arq_len[ar_wp]   <= axi.arlen;
            arq_size[ar_wp]  <= axi.arsize;
            arq_burst[ar_wp] <= axi.arburst;
            ar_wp            <= ar_wp + 1'b1;
         end
         if (ar_pop) ar_rp <= ar_rp + 1'b1;
         ar_cnt <= ar_cnt_nxt;
         ar_rdy <= ar_cnt_nxt != (ARW+1)'(AR_DEPTH);
      end
   end

   // ---------------- Read FSM ----------------
   r_state_t          r_state;
   logic [ADDR_W-1:0] r_start, r_addr, r_addr_nxt;
   logic [3:0]        r_len, r_beat;
   logic [2:0]        r_size;
   logic [1:0]        r_burst;
   logic [ID_W-1:0]   rid_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        rresp_q;
   logic              rvalid_q, rlast_q;

   // A pop happens either from idle or on the last-beat handshake, so bursts chain without a bubble
   assign ar_pop     = (ar_cnt != '0) && (r_state == R_IDLE || (rvalid_q && axi.rready && rlast_q));
   assign r_addr_nxt = (r_burst == 2'b00) ? r_start : r_addr + (ADDR_W'(1) << r_size);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state  <= R_IDLE;
         r_start  <= '0;
         r_addr   <= '0;
         r_len    <= '0;
         r_beat   <= '0;
         r_size   <= '0;
         r_burst  <= '0;
         rid_q    <= '0;
         rdata_q  <= '0;
         rresp_q  <= OKAY;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
      end else if (ar_pop) begin
         r_state  <= R_BURST;
         r_start  <= arq_addr[ar_rp];
         r_addr   <= arq_addr[ar_rp];
         r_len    <= arq_len[ar_rp];
         r_size   <= arq_size[ar_rp];
         r_burst  <= arq_burst[ar_rp];
         r_beat   <= '0;
         rid_q    <= arq_id[ar_rp];
         rdata_q  <= pattern(arq_addr[ar_rp]);
         rresp_q  <= (arq_burst[ar_rp][1] || err_win(arq_addr[ar_rp])) ? SLVERR : OKAY;
         rvalid_q <= 1'b1;
         rlast_q  <= arq_len[ar_rp] == 4'd0;
      end else if (r_state == R_BURST && rvalid_q && axi.rready) begin
         if (rlast_q) begin
            r_state  <= R_IDLE;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
         end else begin
            r_beat  <= r_beat + 4'd1;
            r_addr  <= r_addr_nxt;
            rdata_q <= pattern(r_addr_nxt);
            rlast_q <= (r_beat + 4'd1) == r_len;
         end
      end
   end

   assign axi.arready = ar_rdy;
   assign axi.rid     = rid_q;
   assign axi.rdata   = rdata_q;
   assign axi.rresp   = rresp_q;
   assign axi.rlast   = rlast_q;
   assign axi.rvalid  = rvalid_q;

   // ---------------- AW queue and W accounting ----------------
   logic [ID_W-1:0] awq_id  [AW_DEPTH];
   logic [3:0]      awq_len [AW_DEPTH];
   logic            awq_err [AW_DEPTH];
   logic [AWW-1:0]  aw_wp, aw_rp;
   logic [AWW:0]    aw_cnt, aw_cnt_nxt;
   logic            aw_rdy, aw_push, aw_pop, w_rdy, w_hs;
   logic [4:0]      w_cnt, w_beats;
   logic            w_id_bad, w_id_now;
   logic [1:0]      w_resp;

   assign aw_push    = axi.awvalid && aw_rdy;
   assign w_hs       = axi.wvalid && w_rdy;
   assign aw_pop     = w_hs && axi.wlast;
   assign aw_cnt_nxt = aw_cnt + (AWW+1)'(aw_push) - (AWW+1)'(aw_pop);
   // Beat count saturates just past the longest legal burst so overlong bursts still mismatch
   assign w_beats    = (w_cnt == 5'd17) ? 5'd17 : w_cnt + 5'd1;
   assign w_id_now   = w_id_bad || (axi.wid != awq_id[aw_rp]);
   assign w_resp     = (w_id_now || awq_err[aw_rp] || (w_beats != ({1'b0, awq_len[aw_rp]} + 5'd1)))
                       ? SLVERR : OKAY;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         aw_wp    <= '0;
         aw_rp    <= '0;
         aw_cnt   <= '0;
         aw_rdy   <= 1'b0;
         w_cnt    <= '0;
         w_id_bad <= 1'b0;
      end else begin
         if (aw_push) begin
            awq_id[aw_wp]  <= axi.awid;
            awq_len[aw_wp] <= axi.awlen;
            awq_err[aw_wp] <= err_win(axi.awaddr);
            aw_wp          <= aw_wp + 1'b1;
         end
         if (aw_pop) aw_rp <= aw_rp + 1'b1;
         if (w_hs) begin
            w_cnt    <= axi.wlast ? 5'd0 : w_beats;
            w_id_bad <= axi.wlast ? 1'b0 : w_id_now;
         end
         aw_cnt <= aw_cnt_nxt;
         aw_rdy <= aw_cnt_nxt != (AWW+1)'(AW_DEPTH);
      end
   end

   // ---------------- B queue ----------------
   logic [ID_W-1:0] bq_id   [B_DEPTH];
   logic [1:0]      bq_resp [B_DEPTH];
   logic [BW-1:0]   b_wp, b_rp;
   logic [BW:0]     b_cnt, b_cnt_nxt;
   logic            b_pop;

   assign b_pop     = (b_cnt != '0) && axi.bready;
   assign b_cnt_nxt = b_cnt + (BW+1)'(aw_pop) - (BW+1)'(b_pop);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         b_wp  <= '0;
         b_rp  <= '0;
         b_cnt <= '0;
         w_rdy <= 1'b0;
         for (int i = 0; i < B_DEPTH; i++) begin
            bq_id[i]   <= '0;
            bq_resp[i] <= OKAY;
         end
      end else begin
         if (aw_pop) begin
            bq_id[b_wp]   <= awq_id[aw_rp];
            bq_resp[b_wp] <= w_resp;
            b_wp          <= b_wp + 1'b1;
         end
         if (b_pop) b_rp <= b_rp + 1'b1;
         b_cnt <= b_cnt_nxt;
         w_rdy <= (aw_cnt_nxt != '0) && (b_cnt_nxt != (BW+1)'(B_DEPTH));
      end
   end

   assign axi.awready = aw_rdy;
   assign axi.wready  = w_rdy;
   assign axi.bvalid  = b_cnt != '0;
   assign axi.bid     = bq_id[b_rp];
   assign axi.bresp   = bq_resp[b_rp];
endmodule
